tm1637_display_scheduler: RTL and testbench

//  Sequences digit writes into tm1637_control_core over its data_valid/ready_data byte handshake.

---
 rtl/tm1637_pkg.sv | 35 +++
 rtl/tm1637_seg_decode.sv | 11 +
 rtl/tm1637_display_scheduler.sv | 259 +++++++++++++++++++++++++
 tb/tb_tm1637_display_scheduler.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm1637_pkg.sv
// Shared constants, state encoding and BCD-to-segment table for the TM1637 display scheduler.
package tm1637_pkg;

  localparam logic [7:0] ADDR_CMD_BASE = 8'hC0;
  localparam logic [7:0] SEG_BLANK     = 8'h00;
  localparam int         COLON_BIT     = 7;
  localparam int         COLON_IDX     = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LATCH = 3'd1,
    ST_AW    = 3'd2,
    ST_AP    = 3'd3,
    ST_AK    = 3'd4,
    ST_DW    = 3'd5,
    ST_DP    = 3'd6,
    ST_DK    = 3'd7
  } state_e;

  // Segment order gfedcba, digits 0..9.
  localparam logic [7:0] SEG_TABLE [10] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07, 8'h7F, 8'h6F
  };

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] seg;
    if (bcd <= 4'd9) begin
      seg = SEG_TABLE[bcd];
    end else begin
      seg = SEG_BLANK;
    end
    return seg;
  endfunction

endpackage

// File: rtl/tm1637_seg_decode.sv
// One display position: 4-bit BCD nibble to gfedcba segment byte; non-decimal nibbles blank.
module tm1637_seg_decode
  import tm1637_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/tm1637_display_scheduler.sv
// Refreshes all TM1637 positions through the control core's byte handshake, arbitrating between
// BCD time and held raw-segment messages. Optional colon blink: define TM_COLON_BLINK_EN.
module tm1637_display_scheduler
  import tm1637_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int REFRESH_DIV     = 1000000,
  parameter int MSG_HOLD_FRAMES = 8,
  parameter int BLINK_FRAMES    = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [4*DIGITS-1:0] time_digits,
  input  logic                time_colon,
  input  logic                msg_valid,
  input  logic [8*DIGITS-1:0] msg_segs,
  output logic                msg_busy,
  input  logic                ready_data,
  output logic                data_valid,
  output logic [7:0]          data,
  output logic                frame_done
);

  localparam int IDXW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNTW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int HOLDW = $clog2(MSG_HOLD_FRAMES + 1);
  localparam int FW    = 8 * DIGITS;
  localparam logic [IDXW-1:0]  LAST_IDX  = IDXW'(DIGITS - 1);
  localparam logic [CNTW-1:0]  CNT_LAST  = CNTW'(REFRESH_DIV - 1);
  localparam logic [HOLDW-1:0] HOLD_INIT = HOLDW'(MSG_HOLD_FRAMES);

  if (DIGITS < 1 || DIGITS > 6) begin : g_bad_digits
    $error("DIGITS must be within 1..6 (TM1637 grid limit)");
  end
  if (BLINK_FRAMES < 1 || MSG_HOLD_FRAMES < 1) begin : g_bad_frames
    $error("BLINK_FRAMES and MSG_HOLD_FRAMES must be at least 1");
  end

  state_e           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             tick_q, tick_d;
  logic             pend_q, pend_d;
  logic [FW-1:0]    pend_buf_q, pend_buf_d;
  logic [FW-1:0]    frame_q, frame_d;
  logic             frame_msg_q, frame_msg_d;
  logic [HOLDW-1:0] hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             dv_q, dv_d;
  logic [7:0]       data_q, data_d;
  logic             fd_q, fd_d;

  logic [FW-1:0]    time_seg_s, colon_mask_s, time_frame_s;
  logic             colon_on_s;
  logic             wrap_s;
  logic [2:0]       addr_idx_s;

  assign wrap_s     = (cnt_q == CNT_LAST);
  assign addr_idx_s = 3'(idx_q);

  for (genvar g = 0; g < DIGITS; g++) begin : g_dec
    tm1637_seg_decode u_dec (
      .bcd (time_digits[4*g +: 4]),
      .seg (time_seg_s[8*g +: 8])
    );
  end

  if (DIGITS > COLON_IDX) begin : g_colon
    always_comb begin
      colon_mask_s = '0;
      colon_mask_s[8*COLON_IDX + COLON_BIT] = colon_on_s;
    end
  end else begin : g_no_colon
    assign colon_mask_s = '0;
  end

  assign time_frame_s = time_seg_s | colon_mask_s;

`ifdef TM_COLON_BLINK_EN
  localparam int BLNW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BLNW-1:0] BLINK_LAST = BLNW'(BLINK_FRAMES - 1);

  logic            phase_q, phase_d;
  logic [BLNW-1:0] blink_cnt_q, blink_cnt_d;
  logic            frame_colon_q, frame_colon_d;

  assign colon_on_s = time_colon & phase_q;

  // Phase advances only on completed time frames that actually requested the colon.
  always_comb begin
    phase_d       = phase_q;
    blink_cnt_d   = blink_cnt_q;
    frame_colon_d = frame_colon_q;
    if (state_q == ST_LATCH) begin
      frame_colon_d = time_colon;
    end else begin
      frame_colon_d = frame_colon_q;
    end
    if (fd_d && !frame_msg_q && frame_colon_q) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BLNW'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= 1'b1;
      blink_cnt_q   <= '0;
      frame_colon_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      blink_cnt_q   <= blink_cnt_d;
      frame_colon_q <= frame_colon_d;
    end
  end
`else
  assign colon_on_s = time_colon;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    frame_d     = frame_q;
    frame_msg_d = frame_msg_q;
    hold_d      = hold_q;
    busy_d      = busy_q;
    data_d      = data_q;
    dv_d        = 1'b0;
    fd_d        = 1'b0;
    cnt_d       = wrap_s ? '0 : cnt_q + CNTW'(1);
    tick_d      = tick_q | wrap_s;
    if (msg_valid) begin
      pend_d     = 1'b1;
      pend_buf_d = msg_segs;
    end else begin
      pend_d     = pend_q;
      pend_buf_d = pend_buf_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (tick_q || pend_q) begin
          state_d = ST_LATCH;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LATCH: begin
        idx_d   = '0;
        tick_d  = wrap_s;
        state_d = ST_AW;
        if (pend_q) begin
          frame_d     = pend_buf_q;
          frame_msg_d = 1'b1;
          hold_d      = HOLD_INIT;
          busy_d      = 1'b1;
          pend_d      = msg_valid;
        end else if (hold_q != '0) begin
          // frame_q still holds the message snapshot; replay it.
          frame_msg_d = 1'b1;
        end else begin
          frame_d     = time_frame_s;
          frame_msg_d = 1'b0;
        end
      end
      ST_AW: begin
        if (ready_data) begin
          state_d = ST_AP;
          dv_d    = 1'b1;
          data_d  = ADDR_CMD_BASE | {5'b00000, addr_idx_s};
        end else begin
          state_d = ST_AW;
        end
      end
      ST_AP: state_d = ST_AK;
      ST_AK: begin
        if (!ready_data) begin
          state_d = ST_DW;
        end else begin
          state_d = ST_AK;
        end
      end
      ST_DW: begin
        if (ready_data) begin
          state_d = ST_DP;
          dv_d    = 1'b1;
          data_d  = frame_q[8*idx_q +: 8];
        end else begin
          state_d = ST_DW;
        end
      end
      ST_DP: state_d = ST_DK;
      ST_DK: begin
        if (!ready_data) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_IDLE;
            fd_d    = 1'b1;
            if (frame_msg_q && (hold_q != '0)) begin
              hold_d = hold_q - HOLDW'(1);
              busy_d = (hold_q != HOLDW'(1));
            end else begin
              hold_d = hold_q;
            end
          end else begin
            idx_d   = idx_q + IDXW'(1);
            state_d = ST_AW;
          end
        end else begin
          state_d = ST_DK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      tick_q      <= 1'b1;
      pend_q      <= 1'b0;
      pend_buf_q  <= '0;
      frame_q     <= '0;
      frame_msg_q <= 1'b0;
      hold_q      <= '0;
      busy_q      <= 1'b0;
      dv_q        <= 1'b0;
      data_q      <= 8'h00;
      fd_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      tick_q      <= tick_d;
      pend_q      <= pend_d;
      pend_buf_q  <= pend_buf_d;
      frame_q     <= frame_d;
      frame_msg_q <= frame_msg_d;
      hold_q      <= hold_d;
      busy_q      <= busy_d;
      dv_q        <= dv_d;
      data_q      <= data_d;
      fd_q        <= fd_d;
    end
  end

  assign msg_busy   = busy_q;
  assign data_valid = dv_q;
  assign data       = data_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_tm1637_display_scheduler.sv
// Self-checking bench for tm1637_display_scheduler: frame-level reference model plus a
// responding core model; honours TM_COLON_BLINK_EN when defined.
module tb_tm1637_display_scheduler;

  localparam int DIGITS = 4;
  localparam int RDIV   = 200;
  localparam int HOLD   = 3;
  localparam int BLINK  = 2;
  localparam int BUDGET = 3000;
`ifdef TM_COLON_BLINK_EN
  localparam bit BLINK_EN = 1'b1;
`else
  localparam bit BLINK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] time_digits = 16'h0000;
  logic        time_colon = 1'b0;
  logic        msg_valid = 1'b0;
  logic [31:0] msg_segs = 32'h0;
  logic        msg_busy, ready_data, data_valid, frame_done;
  logic [7:0]  data;

  int n_vec = 0;
  int n_err = 0;
  int viol = 0;
  int core_delay = 0;
  int core_cnt = 0;
  logic [7:0] got[$];
  logic [7:0] last_data;

  // Reference model state, per frame rather than per cycle.
  bit          m_pend;
  logic [31:0] m_pend_segs, m_shown;
  int          m_hold, m_tframes;

  always #5 clk = ~clk;

  tm1637_display_scheduler #(
    .DIGITS(DIGITS), .REFRESH_DIV(RDIV), .MSG_HOLD_FRAMES(HOLD), .BLINK_FRAMES(BLINK)
  ) dut (
    .clk(clk), .reset(reset), .time_digits(time_digits), .time_colon(time_colon),
    .msg_valid(msg_valid), .msg_segs(msg_segs), .msg_busy(msg_busy),
    .ready_data(ready_data), .data_valid(data_valid), .data(data), .frame_done(frame_done)
  );

  // Core model: drops ready on each strobe, raises it again after core_delay extra cycles.
  always @(posedge clk) begin
    if (reset) begin
      ready_data <= 1'b1;
      core_cnt   <= 0;
    end else if (data_valid) begin
      ready_data <= 1'b0;
      core_cnt   <= core_delay;
    end else if (core_cnt > 0) begin
      core_cnt <= core_cnt - 1;
    end else begin
      ready_data <= 1'b1;
    end
  end

  // Byte monitor and protocol watch.
  always @(posedge clk) begin
    if (reset) begin
      last_data <= 8'h00;
    end else if (data_valid === 1'b1) begin
      got.push_back(data);
      last_data <= data;
      if (ready_data !== 1'b1) viol++;
    end else if (data !== last_data) begin
      viol++;
    end
  end

  function automatic logic [7:0] seg_of(input logic [3:0] n);
    case (n)
      4'd0: return 8'h3F;  4'd1: return 8'h06;  4'd2: return 8'h5B;  4'd3: return 8'h4F;
      4'd4: return 8'h66;  4'd5: return 8'h6D;  4'd6: return 8'h7D;  4'd7: return 8'h07;
      4'd8: return 8'h7F;  4'd9: return 8'h6F;
      default: return 8'h00;
    endcase
  endfunction

  task automatic wait_frame(output bit ok);
    int n;
    ok = 1'b0;
    n = 0;
    while (!ok && n < BUDGET) begin
      @(negedge clk);
      n++;
      if (frame_done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic apply_reset(input string name);
    reset = 1'b1;
    msg_valid = 1'b0;
    @(negedge clk);
    n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL %s_dv: got %b want 0", name, data_valid); end
    n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL %s_data: got %h want 00", name, data); end
    n_vec++; if (msg_busy !== 1'b0) begin n_err++; $display("FAIL %s_busy: got %b want 0", name, msg_busy); end
    n_vec++; if (frame_done !== 1'b0) begin n_err++; $display("FAIL %s_fd: got %b want 0", name, frame_done); end
    repeat (2) @(negedge clk);
    got.delete();
    m_pend = 1'b0;
    m_hold = 0;
    m_tframes = 0;
    reset = 1'b0;
  endtask

  // Checks the next frame against the model; inputs must be stable from call until its frame_done.
  task automatic check_frame(input string name, input bit post_msg, input logic [31:0] segs);
    logic [7:0] exp_b [2*DIGITS];
    logic [7:0] s;
    bit is_msg, colon_req, colon_on, ok, exp_busy;
    int v0, n;
    colon_req = time_colon;
    if (m_pend) begin
      is_msg = 1'b1; m_shown = m_pend_segs; m_hold = HOLD; m_pend = 1'b0;
    end else begin
      is_msg = (m_hold > 0);
    end
    colon_on = colon_req && (!BLINK_EN || ((m_tframes / BLINK) % 2 == 0));
    for (int i = 0; i < DIGITS; i++) begin
      exp_b[2*i] = 8'hC0 + 8'(i);
      if (is_msg) s = m_shown[8*i +: 8];
      else begin
        s = seg_of(time_digits[4*i +: 4]);
        if (i == 1 && colon_on) s = s | 8'h80;
      end
      exp_b[2*i+1] = s;
    end
    v0 = viol;
    if (post_msg) begin
      ok = 1'b0; n = 0;
      while (!ok && n < BUDGET) begin
        @(negedge clk); n++;
        if (data_valid === 1'b1 && data === 8'hC2) ok = 1'b1;
      end
      n_vec++;
      if (!ok) begin
        n_err++; $display("FAIL %s_c2: no C2 strobe within %0d cycles", name, BUDGET);
      end else begin
        msg_valid = 1'b1; msg_segs = segs;
        @(negedge clk);
        msg_valid = 1'b0;
        m_pend = 1'b1; m_pend_segs = segs;
      end
    end
    wait_frame(ok);
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL %s_timeout: no frame_done within %0d cycles", name, BUDGET);
      got.delete();
      return;
    end
    n_vec++;
    if (got.size() != 2*DIGITS) begin
      n_err++; $display("FAIL %s_count: got %0d strobes want %0d", name, got.size(), 2*DIGITS);
    end
    for (int i = 0; i < 2*DIGITS; i++) begin
      n_vec++;
      if (i >= got.size()) begin
        n_err++; $display("FAIL %s_byte%0d: missing, want %h", name, i, exp_b[i]);
      end else if (got[i] !== exp_b[i]) begin
        n_err++; $display("FAIL %s_byte%0d: got %h want %h", name, i, got[i], exp_b[i]);
      end
    end
    exp_busy = is_msg && (m_hold > 1);
    n_vec++;
    if (msg_busy !== exp_busy) begin
      n_err++; $display("FAIL %s_busy: got %b want %b", name, msg_busy, exp_busy);
    end
    n_vec++;
    if (viol != v0) begin
      n_err++; $display("FAIL %s_protocol: %0d handshake violations, want 0", name, viol - v0);
    end
    if (is_msg) m_hold--;
    else if (colon_req) m_tframes++;
    got.delete();
  endtask

  task automatic test_reset;
    time_digits = 16'h1234; time_colon = 1'b1; core_delay = 0;
    apply_reset("reset");
  endtask

  task automatic test_basic;
    check_frame("basic_1234", 1'b0, 32'h0);
  endtask

  task automatic test_slow_core;
    core_delay = 50;
    for (int k = 0; k < 2; k++) begin
      time_digits = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
                     4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
      time_colon = 1'($urandom_range(0, 1));
      check_frame("slow_core", 1'b0, 32'h0);
    end
  endtask

  task automatic test_message;
    bit seen;
    core_delay = 0;
    time_digits = 16'h0859; time_colon = 1'b0;
    check_frame("msg_post", 1'b1, 32'h7338_7976);
    seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      @(negedge clk);
      if (data_valid === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin n_err++; $display("FAIL msg_immediate: no strobe within 8 cycles of frame_done"); end
    for (int k = 0; k < HOLD; k++) check_frame("msg_frame", 1'b0, 32'h0);
    check_frame("msg_revert", 1'b0, 32'h0);
  endtask

  task automatic test_blank_decode;
    time_digits = 16'hA0F9; time_colon = 1'b0;
    check_frame("blank_decode", 1'b0, 32'h0);
  endtask

  task automatic test_reset_in_dk;
    bit ok;
    int n, strobes;
    core_delay = 3;
    ok = 1'b0; n = 0; strobes = -1;
    while (!ok && n < BUDGET) begin
      @(negedge clk); n++;
      if (data_valid === 1'b1 && data === 8'hC2) strobes = 0;
      else if (data_valid === 1'b1 && strobes == 0) ok = 1'b1;
    end
    n_vec++;
    if (!ok) begin
      n_err++; $display("FAIL dk_reset_wait: idx2 segment strobe not seen");
    end else begin
      msg_valid = 1'b1; msg_segs = $urandom;
      @(negedge clk);
      msg_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      n_vec++; if (data_valid !== 1'b0) begin n_err++; $display("FAIL dk_reset_dv: got %b want 0", data_valid); end
      n_vec++; if (data !== 8'h00) begin n_err++; $display("FAIL dk_reset_data: got %h want 00", data); end
      n_vec++; if (msg_busy !== 1'b0) begin n_err++; $display("FAIL dk_reset_busy: got %b want 0", msg_busy); end
      @(negedge clk);
      got.delete();
      m_pend = 1'b0; m_hold = 0; m_tframes = 0;
      reset = 1'b0;
    end
    check_frame("after_reset", 1'b0, 32'h0);
  endtask

  task automatic test_blink;
    time_digits = 16'h1234; time_colon = 1'b1; core_delay = 0;
    apply_reset("blink_reset");
    for (int k = 0; k < 5; k++) check_frame("blink", 1'b0, 32'h0);
  endtask

  task automatic test_random;
    for (int k = 0; k < 12; k++) begin
      time_digits = 16'($urandom);
      time_colon = 1'($urandom_range(0, 1));
      core_delay = $urandom_range(0, 4);
      check_frame("random", ($urandom_range(0, 3) == 0), $urandom);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_slow_core;
    test_message;
    test_blank_decode;
    test_reset_in_dk;
    test_blink;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
